// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding, chunk geometry and byte-order helper for the message feeder.
package sha256_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_PAD, ST_LEN, ST_SEND, ST_WAIT} state_t;
  localparam int CHUNK_WORDS = 16;
  localparam int LEN_WORD_IDX = 14;
  localparam logic [7:0] PAD_MARKER = 8'h80;
  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/sha256_chunk_buf.sv
// sha256_chunk_buf: 16x32 chunk register file, one synchronous write port and one async read port.
module sha256_chunk_buf
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_raddr,
  output logic [31:0] o_rdata
);
  logic [31:0] r_mem [CHUNK_WORDS];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sha256_msg_feeder.sv
// sha256_msg_feeder: pads a host byte message into 512-bit chunks and bursts each chunk into the sha256 core.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_bytes,
  input  logic        in_last,
  input  logic        core_busy_i,
  input  logic        core_done_i,
  output logic        dat_valid_o,
  output logic [31:0] dat_lsb_o,
  output logic        busy_o,
  output logic        msg_done_o
);
  state_t r_state, r_resume;
  logic [4:0] r_widx;
  logic [3:0] r_ridx;
  logic [LEN_W-1:0] r_byte_cnt;
  logic r_pad_pending, r_final, r_dat_valid, r_msg_done;
  logic [2:0] w_nb;
  logic w_xfer, w_to_len, w_last_slot, w_we, w_enter_send;
  logic [31:0] w_fill_word, w_wdata, w_rdata;
  logic [63:0] w_len_bits;
  always_comb begin
    w_nb = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    w_xfer = in_valid & in_ready;
    w_len_bits = 64'({r_byte_cnt, 3'b000});
    w_to_len = (r_widx == 5'(LEN_WORD_IDX)) & ~r_pad_pending;
    w_last_slot = r_widx == 5'(CHUNK_WORDS - 1);
    w_we = ((r_state == ST_FILL) & w_xfer) | ((r_state == ST_PAD) & ~w_to_len) | (r_state == ST_LEN);
    w_enter_send = w_we & w_last_slot;
    w_fill_word = in_data;
    for (int k = 0; k < 4; k++)
      w_fill_word[8*k +: 8] = (!in_last || 3'(k) < w_nb) ? in_data[8*k +: 8] :
                              (3'(k) == w_nb) ? PAD_MARKER : 8'h00;
    w_wdata = (r_state == ST_FILL) ? w_fill_word :
              (r_state == ST_PAD) ? {24'h0, r_pad_pending ? PAD_MARKER : 8'h00} :
              byteswap32(r_widx[0] ? w_len_bits[31:0] : w_len_bits[63:32]);
  end
  sha256_chunk_buf u_buf (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_widx[3:0]),
    .i_wdata(w_wdata),
    .i_raddr(r_ridx),
    .o_rdata(w_rdata)
  );
  assign in_ready = (r_state == ST_FILL) & (r_widx < 5'(CHUNK_WORDS));
  assign busy_o = r_state != ST_IDLE;
  assign dat_valid_o = r_dat_valid;
  assign dat_lsb_o = r_dat_valid ? w_rdata : 32'h0;
  assign msg_done_o = r_msg_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_resume <= ST_FILL;
      r_widx <= '0;
      r_ridx <= '0;
      r_byte_cnt <= '0;
      r_pad_pending <= 1'b0;
      r_final <= 1'b0;
      r_dat_valid <= 1'b0;
      r_msg_done <= 1'b0;
    end else begin
      r_msg_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (in_valid) r_state <= ST_FILL;
        ST_FILL: if (w_xfer) begin
          r_widx <= r_widx + 5'd1;
          r_byte_cnt <= r_byte_cnt + (in_last ? LEN_W'(w_nb) : LEN_W'(3'd4));
          if (in_last) begin
            r_pad_pending <= w_nb == 3'd4;
            r_state <= ST_PAD;
          end
        end
        ST_PAD: if (w_to_len) r_state <= ST_LEN;
          else begin
            r_widx <= r_widx + 5'd1;
            r_pad_pending <= 1'b0;
          end
        ST_LEN: r_widx <= r_widx + 5'd1;
        ST_SEND: if (r_dat_valid) begin
          r_ridx <= r_ridx + 4'd1;
          if (r_ridx == 4'(CHUNK_WORDS - 1)) begin
            r_dat_valid <= 1'b0;
            r_widx <= '0;
            r_state <= ST_WAIT;
          end
        end else r_dat_valid <= ~core_busy_i;
        ST_WAIT: if (core_done_i) begin
          if (r_final) begin
            r_msg_done <= 1'b1;
            r_final <= 1'b0;
            r_byte_cnt <= '0;
            r_state <= ST_IDLE;
          end else r_state <= r_resume;
        end
        default: r_state <= ST_IDLE;
      endcase
      // writing the last slot launches the burst directly so the first word follows one cycle later
      if (w_enter_send) begin
        r_state <= ST_SEND;
        r_ridx <= '0;
        r_dat_valid <= ~core_busy_i;
        r_resume <= (r_state == ST_FILL && !in_last) ? ST_FILL : ST_PAD;
        r_final <= r_state == ST_LEN;
      end
    end
  end
endmodule

// File: tb/tb_sha256_msg_feeder.sv
// tb_sha256_msg_feeder: table-driven checks of padding, chunking, core handshake, busy hold and mid-burst reset.
module tb_sha256_msg_feeder;
  logic clk, rst, in_valid, in_ready, in_last, core_busy_i, core_done_i;
  logic dat_valid_o, busy_o, msg_done_o;
  logic [31:0] in_data, dat_lsb_o;
  logic [2:0] in_bytes;
  typedef struct {
    int nbytes;
    bit use7;
    int chunks;
    logic [31:0] len_word;
  } vec_t;
  vec_t tbl[10];
  logic [31:0] cap[$];
  logic [31:0] expw[$];
  int checks = 0, errors = 0;
  int bursts, done_cnt, done_delay, ready_bad;
  logic prev_v;

  sha256_msg_feeder #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bytes(in_bytes), .in_last(in_last), .core_busy_i(core_busy_i), .core_done_i(core_done_i),
    .dat_valid_o(dat_valid_o), .dat_lsb_o(dat_lsb_o), .busy_o(busy_o), .msg_done_o(msg_done_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // core model: captures bursts and answers each full chunk with a done pulse a few cycles later
  initial begin
    core_done_i = 0; done_delay = 0; prev_v = 0; ready_bad = 0; bursts = 0; done_cnt = 0;
    forever begin
      @(negedge clk);
      if (done_delay > 0) begin
        done_delay--;
        core_done_i = (done_delay == 0);
      end else core_done_i = 0;
      if (dat_valid_o) begin
        cap.push_back(dat_lsb_o);
        if (cap.size() % 16 == 0) done_delay = 4;
        if (in_ready) ready_bad++;
      end
      if (dat_valid_o && !prev_v) bursts++;
      prev_v = dat_valid_o;
      if (msg_done_o) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] capw(input int i);
    return (i < cap.size()) ? cap[i] : 32'hxxxxxxxx;
  endfunction

  task automatic build_exp(input int nbytes);
    int total;
    logic [63:0] bits;
    logic [7:0] p;
    logic [31:0] w;
    total = ((nbytes + 72) / 64) * 64;
    bits = 64'(nbytes) * 64'd8;
    expw.delete();
    for (int i = 0; i < total / 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        int b;
        b = 4 * i + k;
        if (b < nbytes) p = 8'(8'h61 + b);
        else if (b == nbytes) p = 8'h80;
        else if (b >= total - 8) p = bits[8*(total-1-b) +: 8];
        else p = 8'h00;
        w[8*k +: 8] = p;
      end
      expw.push_back(w);
    end
  endtask

  task automatic send_msg(input int nbytes, input bit use7);
    int nwords, nb;
    logic [31:0] d;
    nwords = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
    for (int w = 0; w < nwords; w++) begin
      for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(8'h61 + 4 * w + k);
      nb = (w == nwords - 1) ? nbytes - 4 * w : 0;
      if (nb == 4 && use7) nb = 7;
      in_valid = 1; in_data = d; in_last = (w == nwords - 1); in_bytes = 3'(nb);
      for (int t = 0; t < 400 && !in_ready; t++) @(negedge clk);
      chk($sformatf("n%0d_rdy%0d", nbytes, w), 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 0; in_last = 0; in_bytes = 0;
    if (nwords % 16 == 0 && !core_busy_i)
      chk($sformatf("n%0d_latency", nbytes), 32'(dat_valid_o), 32'd1);
  endtask

  task automatic wait_done(input string name);
    for (int t = 0; t < 600 && done_cnt == 0; t++) @(negedge clk);
    chk({name, "_msg_done"}, 32'(done_cnt), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    string n;
    n = $sformatf("n%0d", v.nbytes);
    cap.delete(); bursts = 0; done_cnt = 0;
    build_exp(v.nbytes);
    send_msg(v.nbytes, v.use7);
    wait_done(n);
    chk({n, "_bursts"}, 32'(bursts), 32'(v.chunks));
    chk({n, "_words"}, 32'(cap.size()), 32'(16 * v.chunks));
    for (int i = 0; i < expw.size(); i++) chk($sformatf("%s_w%0d", n, i), capw(i), expw[i]);
    chk({n, "_lenword"}, capw(16 * v.chunks - 1), v.len_word);
    chk({n, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_bytes = 0; in_last = 0; core_busy_i = 0;
    tbl[0] = '{3,  1'b0, 1, 32'h18000000};
    tbl[1] = '{0,  1'b0, 1, 32'h00000000};
    tbl[2] = '{55, 1'b0, 1, 32'hB8010000};
    tbl[3] = '{56, 1'b0, 2, 32'hC0010000};
    tbl[4] = '{64, 1'b0, 2, 32'h00020000};
    tbl[5] = '{52, 1'b0, 1, 32'hA0010000};
    tbl[6] = '{60, 1'b0, 2, 32'hE0010000};
    tbl[7] = '{62, 1'b0, 2, 32'hF0010000};
    tbl[8] = '{65, 1'b0, 2, 32'h08020000};
    tbl[9] = '{8,  1'b1, 1, 32'h40000000};
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(dat_valid_o), 32'd0);
    chk("rst_data", dat_lsb_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(msg_done_o), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) run_vec(tbl[i]);
    // core busy before the burst: no words until it drops
    core_busy_i = 1; cap.delete(); bursts = 0; done_cnt = 0;
    send_msg(3, 1'b0);
    begin
      int vc;
      vc = 0;
      repeat (20) begin
        @(negedge clk);
        if (dat_valid_o) vc++;
      end
      chk("busy_hold_valid", 32'(vc), 32'd0);
    end
    chk("busy_hold_busy", 32'(busy_o), 32'd1);
    core_busy_i = 0;
    @(negedge clk);
    chk("busy_release", 32'(dat_valid_o), 32'd1);
    wait_done("busy");
    chk("busy_bursts", 32'(bursts), 32'd1);
    chk("busy_w0", capw(0), 32'h80636261);
    chk("busy_w15", capw(15), 32'h18000000);
    // asynchronous reset in the middle of a burst
    cap.delete(); bursts = 0; done_cnt = 0;
    send_msg(3, 1'b0);
    for (int t = 0; t < 100 && !dat_valid_o; t++) @(negedge clk);
    repeat (7) @(negedge clk);
    chk("mid_in_send", 32'(dat_valid_o), 32'd1);
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", 32'(dat_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_data", dat_lsb_o, 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    run_vec(tbl[0]);
    chk("abc_w0", capw(0), 32'h80636261);
    chk("abc_w1", capw(1), 32'h00000000);
    chk("abc_w15", capw(15), 32'h18000000);
    chk("ready_during_send", 32'(ready_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_msg_feeder.md
Name: sha256_msg_feeder

Overview:
Host-side transmitter for the sha256 core's word-input interface. It accepts an arbitrary-length byte message as 32-bit words and applies SHA-256 padding: a 0x80 marker, zero fill, and the 64-bit big-endian bit length. It buffers each 512-bit chunk and bursts the 16 words into the core with dat_valid_o. Between chunks it waits for the core's finish pulse. Hash re-initialisation between separate messages is handled outside this block.

Parameters:
LEN_W, 32, width of the message byte counter. Bit length = {byte_cnt, 3'b000}, zero-extended to 64 bits.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  host word valid
in_ready  output  1  block accepts a host word this cycle
in_data  input  32  message word; in_data[7:0] is the earliest byte
in_bytes  input  3  valid bytes in the word (0..4); only sampled with in_last, otherwise 4 implied
in_last  input  1  final word of message
core_busy_i  input  1  core hash_busy_o
core_done_i  input  1  core irq_finish, one-cycle pulse
dat_valid_o  output  1  to core dat_vaild_i
dat_lsb_o  output  32  to core dat_lsb_i, byte-lane order as in_data
busy_o  output  1  high in any state except IDLE
msg_done_o  output  1  one-cycle pulse after the final chunk completes

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-operation aborts immediately, drops dat_valid_o the same cycle, and leaves buffer contents undefined.
- Storage and counters:
  - 16x32 chunk buffer; write index widx 0..16; read index ridx 0..15.
  - byte_cnt (LEN_W bits) wraps modulo 2^LEN_W; no error is flagged on wrap.
  - Flags: pad_pending (0x80 still owed), final (trailer complete in the current chunk).
- Handshake: a word transfers when in_valid & in_ready. in_ready = (state==FILL) & (widx<16).
- IDLE: go to FILL when in_valid.
- FILL:
  - Each transfer writes buf[widx], increments widx and adds 4 to byte_cnt.
  - On in_last: add in_bytes instead of 4. If in_bytes<4, byte lane in_bytes is set to 0x80 and higher lanes to 0; otherwise pad_pending=1. Next state is PAD.
  - If widx reaches 16 without in_last: go to SEND with final=0, then return to FILL after WAIT.
- PAD:
  - One word per cycle. The word is 0x00000080 if pad_pending (which then clears), else 0.
  - If widx==14 and nothing is owed: go to LEN.
  - If widx reaches 16: go to SEND with final=0, then return to PAD after WAIT. The next chunk starts at widx=0 and carries the outstanding marker or zeros.
- LEN: two cycles. buf[14] = byteswap(len_bits[63:32]); buf[15] = byteswap(len_bits[31:0]). Set final=1, go to SEND.
- SEND:
  - Entry is held while core_busy_i=1.
  - Then 16 consecutive cycles with dat_valid_o=1 and dat_lsb_o=buf[ridx], ridx 0..15 with no gaps.
  - Then go to WAIT with widx=0.
- WAIT:
  - On core_done_i: if final, pulse msg_done_o next cycle and go to IDLE; otherwise resume FILL or PAD as recorded.
  - core_done_i outside WAIT is ignored.
- Boundary cases:
  - Empty message: in_last with in_bytes=0 at widx 0.
  - Marker landing in word 14 or 15, or last full word at index 13 or 15, forces an extra chunk.
  - in_bytes>4 is treated as 4.
- Latency: the first dat_valid_o is 1 cycle after the chunk's last buffer write, given core_busy_i=0.

Decomposition:
- Shared package sha256_pkg: state encoding (IDLE, FILL, PAD, LEN, SEND, WAIT), CHUNK_WORDS=16, LEN_WORD_IDX=14, PAD_MARKER=8'h80, byteswap32 function.
- One sub-module sha256_chunk_buf: 16x32 register file with one write port and one read port.

Test Plan:
- "abc": one host word 0x00636261 with in_last, in_bytes=3 -> one chunk.
  - word0 0x80636261, words 1-14 0, word15 0x18000000, msg_done_o.
  - Through the core, the hash is ba7816bf...f20015ad.
- Empty message: in_last, in_bytes=0 -> one chunk, word0 0x00000080, words 1-15 0.
- 55 bytes: 13 full words, then in_bytes=3 -> single chunk with word13 byte3=0x80 and word15 0xB8010000 (440 bits).
- 56 bytes: 14 full words -> word14 0x80 and word15 0 in chunk 1. Chunk 2 is zeros with word15 0xC0010000 (448 bits). Exactly 2 SEND bursts.
- 64 bytes: chunk 1 is all data. Chunk 2 has word0 0x80 and word15 0x00020000. in_ready stays low during SEND/WAIT.
- Core busy held for 20 cycles before SEND -> no dat_valid_o until release. Reset pulse at SEND cycle 7 -> dat_valid_o 0, state IDLE, then a fresh "abc" gives the correct chunk.
